// File: rtl/odd_seq_checker.sv
// odd_seq_checker
//   Tracks a stream of odd counter values (each sample = previous + 2, mod 256)
//   through a HUNT -> VERIFY -> LOCKED state machine and reports lock status,
//   per-sample mismatch pulses and a saturating mismatch count.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous reset, active low
//   in_valid  : in_data is sampled on a rising edge only when high
//   in_data   : observed odd-counter value
//   locked    : high exactly while the FSM is in LOCKED
//   err       : one-cycle pulse per mismatching sample accepted in LOCKED
//   err_cnt   : saturating count of LOCKED mismatches (0 when not built)
//   expected  : next predicted value
//
// Build option
//   ODD_SEQ_CHECKER_ERRCNT_EN : when defined, the err_cnt register is built;
//                               otherwise err_cnt is tied to zero.
module odd_seq_checker #(
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned LOSS_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [7:0] expected
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);

  state_t     state, state_n;
  logic [7:0] exp_q, exp_n;
  logic [3:0] match_q, match_n;
  logic [3:0] miss_q, miss_n;
  logic       err_q, err_n;

  logic [7:0] pred, seed;
  logic [3:0] match_inc, miss_inc;

  assign pred      = exp_q + 8'd2;
  assign seed      = in_data + 8'd2;
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_comb begin
    state_n = state;
    exp_n   = exp_q;
    match_n = match_q;
    miss_n  = miss_q;
    err_n   = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data[0]) begin
            exp_n   = seed;
            match_n = '0;
            state_n = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == exp_q) begin
            match_n = match_inc;
            exp_n   = pred;
            if (match_inc == LOCK_LIM) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else if (in_data[0]) begin
            exp_n   = seed;
            match_n = '0;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          // Prediction advances from the prediction even on a mismatch.
          exp_n = pred;
          if (in_data == exp_q) begin
            miss_n = '0;
          end else begin
            err_n  = 1'b1;
            miss_n = miss_inc;
            if (miss_inc == LOSS_LIM) state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HUNT;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      exp_q   <= exp_n;
      match_q <= match_n;
      miss_q  <= miss_n;
      err_q   <= err_n;
    end
  end

  assign locked   = (state == LOCKED);
  assign err      = err_q;
  assign expected = exp_q;

`ifdef ODD_SEQ_CHECKER_ERRCNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (err_n && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_odd_seq_checker.sv
module tb_odd_seq_checker;

`ifdef ODD_SEQ_CHECKER_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       locked, err;
  logic [7:0] err_cnt, expected;

  odd_seq_checker #(.LOCK_COUNT(2), .LOSS_COUNT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .expected (expected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       e;
    logic [7:0] x;
    logic [7:0] c;
  } vec_t;

  typedef struct {
    bit         chk;
    logic       l;
    logic       e;
    logic [7:0] x;
    logic [7:0] c;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[23];
  int   errors = 0;
  int   checks = 0;

  function automatic void compare(input string tag, input logic wl, input logic we,
                                  input logic [7:0] wx, input logic [7:0] wc);
    checks++;
    if (locked !== wl || err !== we || expected !== wx || err_cnt !== wc) begin
      errors++;
      $display("FAIL %s: got locked=%0d err=%0d expected=%0d err_cnt=%0d, want locked=%0d err=%0d expected=%0d err_cnt=%0d",
               tag, locked, err, expected, err_cnt, wl, we, wx, wc);
    end
  endfunction

  // Drives one sample, pushes its expectation, and compares it after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic wl, input logic we,
                      input logic [7:0] wx, input logic [7:0] wc, input bit chk,
                      input string tag);
    sb_t r;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    sb.push_back('{chk, wl, we, wx, ERRCNT_ON ? wc : 8'd0});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      r = sb.pop_front();
      if (r.chk) compare(tag, r.l, r.e, r.x, r.c);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;

    // in_valid, in_data | locked, err, expected, err_cnt
    tbl[0]  = '{1'b1, 8'd4,  1'b0, 1'b0, 8'd0,  8'd0};
    tbl[1]  = '{1'b1, 8'd6,  1'b0, 1'b0, 8'd0,  8'd0};
    tbl[2]  = '{1'b1, 8'd1,  1'b0, 1'b0, 8'd3,  8'd0};
    tbl[3]  = '{1'b1, 8'd3,  1'b0, 1'b0, 8'd5,  8'd0};
    tbl[4]  = '{1'b1, 8'd5,  1'b1, 1'b0, 8'd7,  8'd0};
    tbl[5]  = '{1'b0, 8'd99, 1'b1, 1'b0, 8'd7,  8'd0};
    tbl[6]  = '{1'b0, 8'd2,  1'b1, 1'b0, 8'd7,  8'd0};
    tbl[7]  = '{1'b0, 8'd7,  1'b1, 1'b0, 8'd7,  8'd0};
    tbl[8]  = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd7,  8'd0};
    tbl[9]  = '{1'b0, 8'd8,  1'b1, 1'b0, 8'd7,  8'd0};
    tbl[10] = '{1'b1, 8'd7,  1'b1, 1'b0, 8'd9,  8'd0};
    tbl[11] = '{1'b1, 8'd9,  1'b1, 1'b0, 8'd11, 8'd0};
    tbl[12] = '{1'b1, 8'd12, 1'b1, 1'b1, 8'd13, 8'd1};
    tbl[13] = '{1'b1, 8'd13, 1'b1, 1'b0, 8'd15, 8'd1};
    tbl[14] = '{1'b1, 8'd0,  1'b1, 1'b1, 8'd17, 8'd2};
    tbl[15] = '{1'b1, 8'd50, 1'b0, 1'b1, 8'd19, 8'd3};
    tbl[16] = '{1'b1, 8'd21, 1'b0, 1'b0, 8'd23, 8'd3};
    tbl[17] = '{1'b1, 8'd25, 1'b0, 1'b0, 8'd27, 8'd3};
    tbl[18] = '{1'b1, 8'd27, 1'b0, 1'b0, 8'd29, 8'd3};
    tbl[19] = '{1'b1, 8'd30, 1'b0, 1'b0, 8'd29, 8'd3};
    tbl[20] = '{1'b1, 8'd31, 1'b0, 1'b0, 8'd33, 8'd3};
    tbl[21] = '{1'b1, 8'd33, 1'b0, 1'b0, 8'd35, 8'd3};
    tbl[22] = '{1'b1, 8'd35, 1'b1, 1'b0, 8'd37, 8'd3};

    #3;
    compare("reset_state", 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int unsigned i = 0; i < 23; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].e, tbl[i].x, tbl[i].c, 1'b1,
           $sformatf("tbl[%0d]", i));
    end

    // Wrap through 255 -> 1 while locked.
    do_reset();
    step(1'b1, 8'd245, 1'b0, 1'b0, 8'd247, 8'd0, 1'b1, "wrap_seed");
    step(1'b1, 8'd247, 1'b0, 1'b0, 8'd249, 8'd0, 1'b1, "wrap_v1");
    step(1'b1, 8'd249, 1'b1, 1'b0, 8'd251, 8'd0, 1'b1, "wrap_lock");
    step(1'b1, 8'd251, 1'b1, 1'b0, 8'd253, 8'd0, 1'b1, "wrap_251");
    step(1'b1, 8'd253, 1'b1, 1'b0, 8'd255, 8'd0, 1'b1, "wrap_253");
    step(1'b1, 8'd255, 1'b1, 1'b0, 8'd1,   8'd0, 1'b1, "wrap_255");
    step(1'b1, 8'd1,   1'b1, 1'b0, 8'd3,   8'd0, 1'b1, "wrap_1");
    step(1'b1, 8'd3,   1'b1, 1'b0, 8'd5,   8'd0, 1'b1, "wrap_3");

    // Lock loss after two mismatches, then relock.
    do_reset();
    step(1'b1, 8'd3,  1'b0, 1'b0, 8'd5,  8'd0, 1'b1, "loss_seed");
    step(1'b1, 8'd5,  1'b0, 1'b0, 8'd7,  8'd0, 1'b1, "loss_v1");
    step(1'b1, 8'd7,  1'b1, 1'b0, 8'd9,  8'd0, 1'b1, "loss_lock");
    step(1'b1, 8'd20, 1'b1, 1'b1, 8'd11, 8'd1, 1'b1, "loss_miss1");
    step(1'b1, 8'd40, 1'b0, 1'b1, 8'd13, 8'd2, 1'b1, "loss_miss2");
    step(1'b1, 8'd41, 1'b0, 1'b0, 8'd43, 8'd2, 1'b1, "relock_seed");
    step(1'b1, 8'd43, 1'b0, 1'b0, 8'd45, 8'd2, 1'b1, "relock_v1");
    step(1'b1, 8'd45, 1'b1, 1'b0, 8'd47, 8'd2, 1'b1, "relock_lock");
    step(1'b1, 8'd0,  1'b1, 1'b1, 8'd49, 8'd3, 1'b1, "cnt3_miss");
    step(1'b1, 8'd49, 1'b1, 1'b0, 8'd51, 8'd3, 1'b1, "cnt3_match");

    // Asynchronous reset between edges while locked.
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    compare("async_reset", 1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'd9, 1'b0, 1'b0, 8'd11, 8'd0, 1'b1, "fresh_seed");

    // err_cnt saturation: alternate mismatch/match so lock is held.
    do_reset();
    step(1'b1, 8'd1, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0, "sat_seed");
    step(1'b1, 8'd3, 1'b0, 1'b0, 8'd5, 8'd0, 1'b0, "sat_v1");
    step(1'b1, 8'd5, 1'b1, 1'b0, 8'd7, 8'd0, 1'b1, "sat_lock");
    e = 8'd7;
    for (int unsigned i = 0; i < 260; i++) begin
      e = e + 8'd2;
      step(1'b1, 8'd0, 1'b1, 1'b1, e, 8'd0, 1'b0, "sat_miss");
      step(1'b1, e, 1'b1, 1'b0, e + 8'd2, 8'd0, 1'b0, "sat_match");
      e = e + 8'd2;
    end
    step(1'b1, 8'd0, 1'b1, 1'b1, e + 8'd2, 8'd255, 1'b1, "sat_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odd_seq_checker.md
ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 2: consecutive matching samples after the seed needed to lock (legal 1..15).
REQ-002 Parameter LOSS_COUNT, default 2: consecutive mismatches while locked that drop lock (legal 1..15).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data is sampled on a rising clk edge only when in_valid is high.
REQ-006 in_data  input  8  observed odd-counter value.
REQ-007 locked  output  1  high while the stream is tracked as a valid odd sequence.
REQ-008 err  output  1  one-cycle pulse per mismatching sample accepted in LOCKED.
REQ-009 err_cnt  output  8  total LOCKED mismatches, saturating.
REQ-010 expected  output  8  next predicted value.

Function
REQ-011 State machine: HUNT, VERIFY, LOCKED; all outputs registered, with 1-cycle latency from the sampling edge.
REQ-012 Prediction arithmetic: next value = accepted value + 2, modulo 256, so 255 wraps to 1.
REQ-013 HUNT behaviour:
- valid odd sample: expected <= in_data+2, match_cnt <= 0, go to VERIFY.
- valid even sample: no state change.
REQ-014 VERIFY, valid sample equal to expected:
- match_cnt increments and expected advances by 2.
- when match_cnt reaches LOCK_COUNT, go to LOCKED.
REQ-015 VERIFY, valid mismatching sample:
- odd: re-seed (expected <= in_data+2, match_cnt <= 0) and stay in VERIFY.
- even: go to HUNT.
- err SHALL NOT pulse.
REQ-016 LOCKED, valid match: expected += 2, miss_cnt <= 0.
REQ-017 LOCKED, valid mismatch:
- err pulses and err_cnt increments.
- miss_cnt increments and expected += 2, i.e. prediction continues from the prediction, not from the data.
- when miss_cnt reaches LOSS_COUNT, go to HUNT; locked falls on the same edge.
REQ-018 in_valid low: no state, counter or expected change; err low.
REQ-019 locked SHALL be high exactly when the state is LOCKED.
REQ-020 err_cnt SHALL saturate at 255; it is not cleared by lock loss, only by reset.

Reset
REQ-021 rst low SHALL immediately, without waiting for a clock edge:
- force state HUNT.
- clear locked, err, err_cnt, expected, match_cnt and miss_cnt.
REQ-022 Reset asserted mid-sequence (any state) SHALL discard all tracking.
REQ-023 After release, the first valid odd sample is treated as a fresh seed.

Configuration
REQ-024 Macro ODD_SEQ_CHECKER_ERRCNT_EN:
- defined: err_cnt behaves per REQ-009/REQ-020.
- undefined: no counter register is built, and err_cnt is tied to 8'd0.
- all other behaviour is identical in both builds.

Verification
REQ-025 Defaults; valid samples 1,3,5 -> locked=1 the cycle after 5 is sampled; expected=7.
REQ-026 Locked; samples 251,253,255,1,3 -> locked stays 1, err never pulses, expected=5.
REQ-027 Locked on expected=9; samples 9,12,13 -> exactly one err pulse (after 12), err_cnt=1, locked stays 1, expected=15.
REQ-028 Locked on expected=9; samples 20,40 -> two err pulses, locked=0 after 40, state HUNT; then 41,43,45 -> locked=1 again, err_cnt=2.
REQ-029 HUNT; sample 4 then 6 -> state stays HUNT, locked=0; in_valid low for 5 cycles in LOCKED -> no output change.
REQ-030 Assert rst low between clock edges while locked with err_cnt=3 -> locked, err_cnt and expected read 0 before the next edge; a build without the macro shows err_cnt=0 throughout REQ-027.
